// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, default datapath width, mul/div FSM encoding.
// No logic, so no latency.
// No flow control; definitions only.
package cpu_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

    function automatic logic op_is_md(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mul_div_step.sv
// One iteration of the mul/div datapath: radix-2 Booth step or restoring-divide step.
// Purely combinational, zero latency.
// No flow control; the owning FSM decides when the result is registered.
module mul_div_step
    import cpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             is_div,
    input  logic [WIDTH:0]   hi,
    input  logic [WIDTH-1:0] lo,
    input  logic             q_m1,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   hi_nxt,
    output logic [WIDTH-1:0] lo_nxt,
    output logic             q_m1_nxt
);

    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH+1:0] trial;

    // hi carries one guard bit so that subtracting the most negative multiplicand cannot overflow
    assign m_ext = {m[WIDTH-1], m};

    always_comb begin
        booth_sum = hi;
        case ({lo[0], q_m1})
            2'b01:   booth_sum = hi + m_ext;
            2'b10:   booth_sum = hi - m_ext;
            default: booth_sum = hi;
        endcase

        r_sh  = {hi[WIDTH-1:0], lo[WIDTH-1]};
        trial = {1'b0, r_sh} - {2'b00, m};

        hi_nxt   = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        lo_nxt   = {booth_sum[0], lo[WIDTH-1:1]};
        q_m1_nxt = lo[0];

        if (is_div) begin
            // a negative trial means the divisor did not fit: keep the shifted remainder
            hi_nxt   = trial[WIDTH+1] ? r_sh : trial[WIDTH:0];
            lo_nxt   = {lo[WIDTH-2:0], ~trial[WIDTH+1]};
            q_m1_nxt = 1'b0;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply / divide (Booth, restoring); optional MUL_DIV_TRIVIAL_BYPASS_EN fast path.
// Latency: 33 edges start-to-done; divide-by-zero (and bypassed trivial ops) finish after 1 edge.
// Backpressure: start is only taken in IDLE with no fast result pending; otherwise ignored.
module mul_div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               start,
    input  logic [4:0]         opcode,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] C,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero
);

    md_state_t state_q, state_d;

    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH:0]     hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               q_m1_q;
    logic [WIDTH-1:0]   m_q;
    logic               op_div_q;
    logic               sign_a_q;
    logic               sign_b_q;
    logic [2*WIDTH-1:0] c_q;
    logic               dbz_q;
    logic               pend_q;
    logic               pend_dbz_q;

    logic               accept;
    logic               is_div_in;
    logic               fast_in;
    logic               dbz_in;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     hi_nxt;
    logic [WIDTH-1:0]   lo_nxt;
    logic               q_m1_nxt;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic [2*WIDTH-1:0] fix_c;

    assign is_div_in = (opcode == OP_DIV);
    assign dbz_in    = is_div_in && (B == '0);
    assign accept    = (state_q == ST_IDLE) && !pend_q && start && op_is_md(opcode);
    assign a_mag     = A[WIDTH-1] ? -A : A;
    assign b_mag     = B[WIDTH-1] ? -B : B;

`ifdef MUL_DIV_TRIVIAL_BYPASS_EN
    assign fast_in = dbz_in
                   || (!is_div_in && ((A == '0) || (B == '0)))
                   || (is_div_in && (B == WIDTH'(1)));
`else
    assign fast_in = dbz_in;
`endif

    mul_div_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (op_div_q),
        .hi       (hi_q),
        .lo       (lo_q),
        .q_m1     (q_m1_q),
        .m        (m_q),
        .hi_nxt   (hi_nxt),
        .lo_nxt   (lo_nxt),
        .q_m1_nxt (q_m1_nxt)
    );

    // quotient sign is the XOR of operand signs; remainder follows the dividend
    assign q_fix = (sign_a_q ^ sign_b_q) ? -lo_q : lo_q;
    assign r_fix = sign_a_q ? -hi_q[WIDTH-1:0] : hi_q[WIDTH-1:0];
    assign fix_c = op_div_q ? {r_fix, q_fix} : {hi_q[WIDTH-1:0], lo_q};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    state_d = ST_DONE;
                end else if (accept && !fast_in) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  if (cnt_q == CNT_W'(WIDTH-1)) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            q_m1_q     <= 1'b0;
            m_q        <= '0;
            op_div_q   <= 1'b0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            c_q        <= '0;
            dbz_q      <= 1'b0;
            pend_q     <= 1'b0;
            pend_dbz_q <= 1'b0;
        end else begin
            pend_q <= accept && fast_in;

            if (accept) begin
                dbz_q      <= 1'b0;
                op_div_q   <= is_div_in;
                sign_a_q   <= A[WIDTH-1];
                sign_b_q   <= B[WIDTH-1];
                cnt_q      <= '0;
                q_m1_q     <= 1'b0;
                pend_dbz_q <= dbz_in;
                if (dbz_in) begin
                    hi_q <= {1'b0, A};
                    lo_q <= '1;
                end else if (fast_in && is_div_in) begin
                    hi_q <= '0;
                    lo_q <= A;
                end else if (fast_in) begin
                    hi_q <= '0;
                    lo_q <= '0;
                end else if (is_div_in) begin
                    hi_q <= '0;
                    lo_q <= a_mag;
                    m_q  <= b_mag;
                end else begin
                    hi_q <= '0;
                    lo_q <= B;
                    m_q  <= A;
                end
            end

            // fast results were staged in hi/lo at accept and land in C one edge later
            if (pend_q) begin
                c_q   <= {hi_q[WIDTH-1:0], lo_q};
                dbz_q <= pend_dbz_q;
            end

            if (state_q == ST_RUN) begin
                hi_q   <= hi_nxt;
                lo_q   <= lo_nxt;
                q_m1_q <= q_m1_nxt;
                cnt_q  <= cnt_q + CNT_W'(1);
            end

            if (state_q == ST_FIX) begin
                c_q   <= fix_c;
                cnt_q <= '0;
            end
        end
    end

    assign C           = c_q;
    assign busy        = (state_q == ST_RUN) || (state_q == ST_FIX);
    assign done        = (state_q == ST_DONE);
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed + random checks of mul_div_unit against a plain-arithmetic reference model.
module tb_mul_div_unit;
    import cpu_pkg::*;

    logic        clk;
    logic        clear;
    logic        start;
    logic [4:0]  opcode;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [63:0] res_c;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;
    logic [63:0] last_c;

    mul_div_unit dut (
        .clk         (clk),
        .clear       (clear),
        .start       (start),
        .opcode      (opcode),
        .A           (op_a),
        .B           (op_b),
        .C           (res_c),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
    endfunction

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint la, lb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        la = longint'($signed(a));
        lb = longint'($signed(b));
        q  = la / lb;
        r  = la % lb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic bit is_fast(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bit f;
        f = (op == OP_DIV) && (b == 32'd0);
`ifdef MUL_DIV_TRIVIAL_BYPASS_EN
        f = f || ((op == OP_MUL) && (a == 32'd0 || b == 32'd0)) || ((op == OP_DIV) && (b == 32'd1));
`else
        if (a == 32'hDEAD_BEEF) f = f;
`endif
        return f;
    endfunction

    // Issue one op; intf_k >= 1 raises a second start so it is sampled at edge intf_k.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int intf_k, input string tag);
        logic [63:0] exp_c;
        bit          fast;
        int          k, busy_n, both_n;
        exp_c  = (op == OP_DIV) ? ref_div(a, b) : ref_mul(a, b);
        fast   = is_fast(op, a, b);
        @(negedge clk);
        start = 1'b1; opcode = op; op_a = a; op_b = b;
        @(posedge clk); #1;
        start  = 1'b0;
        k      = 0;
        busy_n = 0;
        both_n = 0;
        chk({tag, "_dbz_clr"}, {63'd0, div_by_zero}, 64'd0);
        chk({tag, "_c_hold"}, res_c, last_c);
        while (!done && k < 60) begin
            if (busy) busy_n++;
            if (k == intf_k - 1) begin
                start = 1'b1; opcode = OP_DIV; op_a = 32'd100; op_b = 32'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            k++;
            if (busy && done) both_n++;
        end
        start = 1'b0;
        chk({tag, "_lat"}, 64'(k), fast ? 64'd1 : 64'd33);
        chk({tag, "_busy_cycles"}, 64'(busy_n), fast ? 64'd0 : 64'd33);
        chk({tag, "_busy_done_excl"}, 64'(both_n), 64'd0);
        chk({tag, "_c"}, res_c, exp_c);
        chk({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, (op == OP_DIV) && (b == 32'd0)});
        last_c = exp_c;
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, {62'd0, done, busy}, 64'd0);
    endtask

    initial begin
        logic [4:0]  rop;
        logic [31:0] ra, rb;
        int          saw;

        clear = 1'b1; start = 1'b0; opcode = 5'd0; op_a = '0; op_b = '0;
        last_c = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_c", res_c, 64'd0);
        chk("rst_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        clear = 1'b0;

        run_op(OP_MUL, 32'd6, 32'd7, -1, "mul_pos");
        run_op(OP_MUL, -32'sd3, 32'd5, -1, "mul_sgn");
        run_op(OP_MUL, 32'h8000_0000, 32'h8000_0000, -1, "mul_ext");
        run_op(OP_DIV, -32'sd7, 32'd2, -1, "div_sgn");
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div_ovf");
        run_op(OP_DIV, 32'd5, 32'd0, -1, "div_zero");
        run_op(OP_MUL, 32'd11, -32'sd4, -1, "mul_after_dbz");
        run_op(OP_DIV, 32'd9, -32'sd4, -1, "div_pos_neg");

        // invalid opcode is ignored
        @(negedge clk);
        start = 1'b1; opcode = 5'h05; op_a = 32'd3; op_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        chk("inv_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        chk("inv_idle", {62'd0, busy, done}, 64'd0);
        chk("inv_c", res_c, last_c);

        // second start at edge 5 is ignored; nothing starts afterwards
        run_op(OP_MUL, 32'd1234, 32'd567, 5, "mul_intf");
        repeat (3) @(posedge clk);
        #1;
        chk("intf_no_restart", {62'd0, busy, done}, 64'd0);

        // clear at edge 10 of a mul
        @(negedge clk);
        start = 1'b1; opcode = OP_MUL; op_a = 32'd77; op_b = 32'd99;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clr_busy", {63'd0, busy}, 64'd0);
        chk("clr_c", res_c, 64'd0);
        saw = 0;
        repeat (40) begin
            if (done || busy) saw++;
            @(posedge clk); #1;
        end
        chk("clr_no_done", 64'(saw), 64'd0);
        last_c = '0;

        run_op(OP_MUL, -32'sd1000, -32'sd1000, -1, "mul_after_clr");
        run_op(OP_MUL, 32'd0, 32'd9, -1, "mul_bypass");
        run_op(OP_DIV, -32'sd12345, 32'd1, -1, "div_by_one");

        for (int i = 0; i < 10; i++) begin
            rop = ($urandom_range(0, 1) == 0) ? OP_MUL : OP_DIV;
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'd1;
                2: ra = 32'd0;
                3: rb = 32'($urandom_range(0, 40)) - 32'd20;
                default: ;
            endcase
            run_op(rop, ra, rb, -1, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
